// File: rtl/risc4_pkg.sv
// Shared definitions for the 4-bit core: ALU opcodes, the load/exchange
// opcodes that share the opcode space, and the sequencer state encoding.
// Both the sequencer and its sibling ALU import this package.
package risc4_pkg;

    // ALU operations (opcodes 0-7)
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    // Register-file transfer operations
    localparam logic [3:0] OP_LDR = 4'd8;
    localparam logic [3:0] OP_XCH = 4'd9;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RETIRE = 2'd3
    } seq_state_e;

    // Opcodes 10-15 are not defined and retire with an error.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op >= 4'd10;
    endfunction

    // Opcodes 0-7 take their result from the ALU.
    function automatic logic op_is_alu(input logic [3:0] op);
        return ~op[3];
    endfunction

    // Only the arithmetic ops (ADD/ADC/SUB/SBB) update the carry flag.
    function automatic logic op_writes_carry(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    // Add-with-carry and subtract-with-borrow consume the carry flag.
    function automatic logic op_uses_cin(input logic [3:0] op);
        return (op == OP_ADC) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of every non-clock signal of the sequencer: instruction handshake,
// register-file read/write ports, the ALU operand/result bus and the
// architectural status outputs. The master view belongs to the sequencer,
// the slave view to the surrounding core (register file, ALU, issue logic).
interface alu_sequencer_if;

    // Instruction handshake
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [3:0] instr_rs;

    // Register-file read port (data returns one cycle after rf_rd_en)
    logic       rf_rd_en;
    logic [3:0] rf_rd_addr;
    logic [3:0] rf_rd_data;

    // Register-file write port (exchange only)
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [3:0] rf_wr_data;

    // Sibling ALU
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_cout;
    logic       alu_zero;

    // Architectural state and retirement status
    logic [3:0] acc;
    logic       carry;
    logic       zflag;
    logic       done;
    logic       err;

    modport master (
        input  instr_valid, instr_op, instr_rs,
        output instr_ready,
        output rf_rd_en, rf_rd_addr,
        input  rf_rd_data,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_result, alu_cout, alu_zero,
        output acc, carry, zflag, done, err
    );

    modport slave (
        output instr_valid, instr_op, instr_rs,
        input  instr_ready,
        input  rf_rd_en, rf_rd_addr,
        output rf_rd_data,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_result, alu_cout, alu_zero,
        input  acc, carry, zflag, done, err
    );

endinterface

// File: rtl/alu.sv
// 4-bit combinational ALU, the sibling of the sequencer at core level.
// Subtractions report a borrow on cout; SLT is an unsigned compare.
// Logic ops and SLT return cout=0; opcodes 8-15 return zero.
module alu
    import risc4_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] op_i,
    input  logic       cin_i,
    output logic [3:0] result_o,
    output logic       cout_o,
    output logic       zero_o
);

    logic [4:0] wide;

    // Evaluate the selected operation with one extra bit for carry/borrow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        wide = 5'd0;
        unique case (op_i)
            OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            OP_ADC:  wide = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
            OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            OP_SBB:  wide = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cin_i};
            OP_AND:  wide = {1'b0, a_i & b_i};
            OP_OR:   wide = {1'b0, a_i | b_i};
            OP_XOR:  wide = {1'b0, a_i ^ b_i};
            OP_SLT:  wide = {4'd0, (a_i < b_i)};
            default: wide = 5'd0;
        endcase
    end

    assign result_o = wide[3:0];
    assign cout_o   = wide[4];
    assign zero_o   = (wide[3:0] == 4'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer for the 4-bit core. Each accepted
// instruction walks IDLE -> READ -> EXEC -> RETIRE: READ fetches the operand
// register, EXEC drives the sibling ALU (or moves register data) and commits
// the accumulator and flags on its closing edge, RETIRE pulses done.
// Illegal opcodes skip the read and EXEC and retire with err.
module alu_sequencer
    import risc4_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.master bus
);

    seq_state_e state_q, state_d;
    logic [3:0] op_q,    op_d;
    logic [3:0] rs_q,    rs_d;
    logic [3:0] acc_q,   acc_d;
    logic       carry_q, carry_d;
    logic       zflag_q, zflag_d;

    logic in_exec;
    logic illegal;
    logic accept;

    assign in_exec = (state_q == ST_EXEC);
    assign illegal = op_is_illegal(op_q);

    // Ready is masked by reset so nothing is accepted while rst is high.
    assign bus.instr_ready = (state_q == ST_IDLE) & ~rst;
    assign accept          = bus.instr_valid & bus.instr_ready;

    // Next-state and architectural-register update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zflag_d = zflag_q;

        unique case (state_q)
            ST_IDLE: begin
                // op/rs are captured here so later changes on the
                // instruction inputs cannot disturb the in-flight op.
                if (accept) begin
                    op_d    = bus.instr_op;
                    rs_d    = bus.instr_rs;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                state_d = illegal ? ST_RETIRE : ST_EXEC;
            end

            ST_EXEC: begin
                // Illegal opcodes never reach EXEC, so op_q is 0-9 here.
                if (op_is_alu(op_q)) begin
                    acc_d   = bus.alu_result;
                    zflag_d = bus.alu_zero;
                    if (op_writes_carry(op_q)) begin
                        carry_d = bus.alu_cout;
                    end
                end else begin
                    // LDR and XCH both load the register value.
                    acc_d   = bus.rf_rd_data;
                    zflag_d = (bus.rf_rd_data == 4'd0);
                end
                state_d = ST_RETIRE;
            end

            ST_RETIRE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and architectural registers; reset aborts any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            rs_q    <= 4'd0;
            acc_q   <= 4'd0;
            carry_q <= 1'b0;
            zflag_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zflag_q <= zflag_d;
        end
    end

    // Register-file request outputs; every strobe is a decode of the state.
    always_comb begin
        bus.rf_rd_en   = (state_q == ST_READ) & ~illegal;
        bus.rf_rd_addr = bus.rf_rd_en ? rs_q : 4'd0;

        // The write carries the pre-exchange accumulator; acc_q only
        // takes the register value on the closing edge of EXEC.
        bus.rf_wr_en   = in_exec & (op_q == OP_XCH);
        bus.rf_wr_addr = bus.rf_wr_en ? rs_q  : 4'd0;
        bus.rf_wr_data = bus.rf_wr_en ? acc_q : 4'd0;
    end

    // ALU operand bus: live only during EXEC, held at zero otherwise.
    always_comb begin
        bus.alu_a   = 4'd0;
        bus.alu_b   = 4'd0;
        bus.alu_op  = 4'd0;
        bus.alu_cin = 1'b0;
        if (in_exec) begin
            bus.alu_a   = acc_q;
            bus.alu_b   = bus.rf_rd_data;
            bus.alu_op  = op_q;
            bus.alu_cin = op_uses_cin(op_q) ? carry_q : 1'b0;
        end
    end

    // Architectural status and retirement pulses.
    assign bus.acc   = acc_q;
    assign bus.carry = carry_q;
    assign bus.zflag = zflag_q;
    assign bus.done  = (state_q == ST_RETIRE);
    assign bus.err   = (state_q == ST_RETIRE) & illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a register-file model with one-cycle
// read latency, the sibling ALU, and a sequence of instructions whose
// accumulator/flag results are worked out by hand in the table comments.
module tb_alu_sequencer;
    import risc4_pkg::*;

    logic clk;
    logic rst;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sibling ALU wired at core level
    logic [3:0] alu_a, alu_b, alu_op, alu_result;
    logic       alu_cin, alu_cout, alu_zero;

    assign alu_a          = bus.alu_a;
    assign alu_b          = bus.alu_b;
    assign alu_op         = bus.alu_op;
    assign alu_cin        = bus.alu_cin;
    assign bus.alu_result = alu_result;
    assign bus.alu_cout   = alu_cout;
    assign bus.alu_zero   = alu_zero;

    alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .cin_i    (alu_cin),
        .result_o (alu_result),
        .cout_o   (alu_cout),
        .zero_o   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: r1=1 r2=3 r3=5 r4=6 r5=F r6=F r7=A, others 0
    logic [3:0] regs [16] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h6, 4'hF, 4'hF, 4'hA,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    always @(posedge clk) begin
        if (bus.rf_rd_en) bus.rf_rd_data <= regs[bus.rf_rd_addr];
        if (bus.rf_wr_en) regs[bus.rf_wr_addr] <= bus.rf_wr_data;
    end

    // Event counters (monotonic; tests compare deltas)
    int         rd_cnt = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
    logic [7:0] wr_last = 8'h00;

    always @(posedge clk) begin
        if (bus.rf_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.rf_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_last <= {bus.rf_wr_addr, bus.rf_wr_data};
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_arch(input string tag, input logic [3:0] a, input logic c, input logic z);
        check({tag, "_acc"},   {12'd0, bus.acc},   {12'd0, a});
        check({tag, "_carry"}, {15'd0, bus.carry}, {15'd0, c});
        check({tag, "_zflag"}, {15'd0, bus.zflag}, {15'd0, z});
    endtask

    // Called just after a negedge with the sequencer idle. Offers one
    // instruction, follows it to retirement and returns just after the
    // negedge following the done pulse (sequencer idle again).
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] rs,
                             input bit hold, input bit exp_err, input bit exp_wr);
        int lat;
        int rd0, wr0, acc0;
        logic wr_exec;
        rd0  = rd_cnt;
        wr0  = wr_cnt;
        acc0 = acc_cnt;
        check({tag, "_ready"}, {15'd0, bus.instr_ready}, 16'd1);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rs    = rs;
        @(negedge clk);
        lat = 1;
        if (!hold) begin
            // Scramble the inputs; the in-flight instruction must ignore them
            bus.instr_valid = 1'b0;
            bus.instr_op    = 4'hE;
            bus.instr_rs    = ~rs;
        end
        check({tag, "_alu_idle"}, {3'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 16'd0);
        check({tag, "_rd_en"}, {15'd0, bus.rf_rd_en}, {15'd0, ~exp_err});
        wr_exec = 1'b0;
        while (!bus.done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 2) wr_exec = bus.rf_wr_en;
        end
        check({tag, "_latency"}, lat[15:0], exp_err ? 16'd2 : 16'd3);
        check({tag, "_err"}, {15'd0, bus.err}, {15'd0, exp_err});
        check({tag, "_wr_in_exec"}, {15'd0, wr_exec}, {15'd0, exp_wr});
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, {14'd0, bus.done, bus.err}, 16'd0);
        check({tag, "_rd_count"}, 16'(rd_cnt - rd0), exp_err ? 16'd0 : 16'd1);
        check({tag, "_wr_count"}, 16'(wr_cnt - wr0), {15'd0, exp_wr});
        check({tag, "_accepts"},  16'(acc_cnt - acc0), 16'd1);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 4'h0;
        bus.instr_rs    = 4'h0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {15'd0, bus.instr_ready}, 16'd0);
        check("rst_strobes", {12'd0, bus.done, bus.err, bus.rf_rd_en, bus.rf_wr_en}, 16'd0);
        check("rst_alu", {3'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 16'd0);
        check_arch("rst", 4'h0, 1'b0, 1'b1);

        // First acceptance on the first rising edge after release
        rst = 1'b0;
        #1;
        run_instr("ldr_r3", OP_LDR, 4'd3, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_r3", 4'h5, 1'b0, 1'b0);

        // 0xF + 1 wraps to 0 with carry out; then 0 + 1 + carry = 2
        run_instr("ldr_r5", OP_LDR, 4'd5, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_r5", 4'hF, 1'b0, 1'b0);
        run_instr("add_r1", OP_ADD, 4'd1, 1'b0, 1'b0, 1'b0);
        check_arch("add_r1", 4'h0, 1'b1, 1'b1);
        run_instr("adc_r1", OP_ADC, 4'd1, 1'b0, 1'b0, 1'b0);
        check_arch("adc_r1", 4'h2, 1'b0, 1'b0);

        // 2 + F = 0x11 sets carry; LDR keeps carry; 3 - 3 - 1 = F with borrow
        run_instr("add_r6", OP_ADD, 4'd6, 1'b0, 1'b0, 1'b0);
        check_arch("add_r6", 4'h1, 1'b1, 1'b0);
        run_instr("ldr_r2", OP_LDR, 4'd2, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_r2", 4'h3, 1'b1, 1'b0);
        run_instr("sbb_r2", OP_SBB, 4'd2, 1'b0, 1'b0, 1'b0);
        check_arch("sbb_r2", 4'hF, 1'b1, 1'b0);
        run_instr("and_r2", OP_AND, 4'd2, 1'b0, 1'b0, 1'b0);
        check_arch("and_r2", 4'h3, 1'b1, 1'b0);

        // Illegal opcode with valid held high through the busy period
        run_instr("ill_c", 4'hC, 4'd2, 1'b1, 1'b1, 1'b0);
        check_arch("ill_c", 4'h3, 1'b1, 1'b0);

        // Exchange: r4 (6) <-> acc (A)
        run_instr("ldr_r7", OP_LDR, 4'd7, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_r7", 4'hA, 1'b1, 1'b0);
        run_instr("xch_r4", OP_XCH, 4'd4, 1'b0, 1'b0, 1'b1);
        check_arch("xch_r4", 4'h6, 1'b1, 1'b0);
        check("xch_wr_word", {8'd0, wr_last}, 16'h004A);
        check("xch_r4_mem", {12'd0, regs[4]}, 16'h000A);

        // 6-1=5 no borrow; 5|3=7; 7<3 false; 0-1=F borrow; F^F=0; 0<1 true
        run_instr("sub_r1", OP_SUB, 4'd1, 1'b0, 1'b0, 1'b0);
        check_arch("sub_r1", 4'h5, 1'b0, 1'b0);
        run_instr("or_r2", OP_OR, 4'd2, 1'b0, 1'b0, 1'b0);
        check_arch("or_r2", 4'h7, 1'b0, 1'b0);
        run_instr("slt_r2", OP_SLT, 4'd2, 1'b0, 1'b0, 1'b0);
        check_arch("slt_r2", 4'h0, 1'b0, 1'b1);
        run_instr("sub_wrap", OP_SUB, 4'd1, 1'b0, 1'b0, 1'b0);
        check_arch("sub_wrap", 4'hF, 1'b1, 1'b0);
        run_instr("xor_r5", OP_XOR, 4'd5, 1'b0, 1'b0, 1'b0);
        check_arch("xor_r5", 4'h0, 1'b1, 1'b1);
        run_instr("slt_r1", OP_SLT, 4'd1, 1'b0, 1'b0, 1'b0);
        check_arch("slt_r1", 4'h1, 1'b1, 1'b0);

        // Reset during the EXEC cycle of an exchange
        run_instr("ldr_r3b", OP_LDR, 4'd3, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_r3b", 4'h5, 1'b1, 1'b0);
        begin
            int done0, wr0;
            bus.instr_valid = 1'b1;
            bus.instr_op    = OP_XCH;
            bus.instr_rs    = 4'd4;
            @(negedge clk);
            bus.instr_valid = 1'b0;
            @(negedge clk);
            check("abort_wr_pre", {15'd0, bus.rf_wr_en}, 16'd1);
            done0 = done_cnt;
            wr0   = wr_cnt;
            #1 rst = 1'b1;
            #1;
            check("abort_wr_en", {15'd0, bus.rf_wr_en}, 16'd0);
            check("abort_ready", {15'd0, bus.instr_ready}, 16'd0);
            check_arch("abort", 4'h0, 1'b0, 1'b1);
            @(negedge clk);
            @(negedge clk);
            check("abort_no_done", 16'(done_cnt - done0), 16'd0);
            check("abort_no_write", 16'(wr_cnt - wr0), 16'd0);
            check("abort_r4_mem", {12'd0, regs[4]}, 16'h000A);
            rst = 1'b0;
            #1;
        end
        run_instr("ldr_after", OP_LDR, 4'd3, 1'b0, 1'b0, 1'b0);
        check_arch("ldr_after", 4'h5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-002 SHALL have no parameters; all widths fixed at 4-bit data, 4-bit register index.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  async active-high reset.
REQ-005 instr_valid  input  1  instruction offered this cycle.
REQ-006 instr_ready  output  1  sequencer idle and able to accept.
REQ-007 instr_op  input  4  opcode: 0-7 ALU ops (ADD,ADC,SUB,SBB,AND,OR,XOR,SLT), 8 LDR, 9 XCH, 10-15 illegal.
REQ-008 instr_rs  input  4  index-register number for operand B.
REQ-009 rf_rd_en / rf_rd_addr  output  1/4  register-file read request; data valid one cycle later.
REQ-010 rf_rd_data  input  4  register-file read data.
REQ-011 rf_wr_en / rf_wr_addr / rf_wr_data  output  1/4/4  register-file write port (XCH only).
REQ-012 alu_a / alu_b / alu_op / alu_cin  output  4/4/4/1  drive the sibling alu instance.
REQ-013 alu_result / alu_cout / alu_zero  input  4/1/1  from the alu instance.
REQ-014 acc  output  4  accumulator; carry  output  1  carry flag; zflag  output  1  zero flag.
REQ-015 done  output  1  one-cycle pulse at instruction retirement; err  output  1  pulses with done on illegal opcode.

Function
REQ-016 SHALL implement FSM states IDLE, READ, EXEC, RETIRE.
REQ-017 instr_ready SHALL equal (state==IDLE) & ~rst; acceptance = instr_valid & instr_ready at a rising edge.
REQ-018 On acceptance SHALL latch op and rs, move IDLE->READ.
REQ-019 READ: SHALL drive rf_rd_en=1, rf_rd_addr=latched rs for exactly one cycle; next state EXEC; illegal op SHALL skip read (rf_rd_en=0) and go directly to RETIRE.
REQ-020 EXEC: alu_a=acc, alu_b=rf_rd_data, alu_op=latched op[3:0]; alu_cin=0 for ADD/SUB/logic/SLT, =carry for ADC/SBB.
REQ-021 Outside EXEC, alu_a/alu_b/alu_op/alu_cin SHALL be 0.
REQ-022 EXEC edge, ops 0-7: acc<=alu_result, zflag<=alu_zero; carry<=alu_cout for ops 0-3 only, unchanged for ops 4-7.
REQ-023 EXEC edge, LDR: acc<=rf_rd_data, zflag<=(rf_rd_data==0), carry unchanged.
REQ-024 EXEC, XCH: rf_wr_en=1, rf_wr_addr=rs, rf_wr_data=old acc in same cycle; acc<=rf_rd_data, zflag updated, carry unchanged.
REQ-025 rf_wr_en SHALL be 0 in every state/op other than EXEC with XCH.
REQ-026 RETIRE: done=1 for one cycle, err=1 iff op>=10; illegal op leaves acc, carry, zflag unchanged; next state IDLE.
REQ-027 Latency: acceptance edge to done high = 3 cycles (2 for illegal); throughput one instruction per 4 cycles; instr_valid while not ready SHALL be ignored, no queuing.
REQ-028 Accumulator arithmetic SHALL be modulo 16; wrap (e.g. 0xF+1) relies on alu_cout, no saturation.
REQ-029 Changes to instr_op/instr_rs after acceptance SHALL NOT affect the in-flight instruction.

Reset
REQ-030 While rst high: state=IDLE, acc=0, carry=0, zflag=1, done=0, err=0, instr_ready=0, rf_rd_en=0, rf_wr_en=0, ALU drives 0.
REQ-031 Reset asserted mid-instruction SHALL abort it with no register-file write and no done pulse.
REQ-032 First acceptance possible at first rising edge after rst deasserts.

Structure
REQ-033 ALU opcode constants, LDR/XCH opcodes and FSM state enum SHALL live in shared package risc4_pkg, also used by alu.
REQ-034 No sub-module; alu remains a sibling instance connected at core level.

Verification
REQ-035 Reset, acc=0; LDR r3 (r3=0x5) -> done at +3 cycles, acc=0x5, zflag=0, carry=0.
REQ-036 acc=0xF, carry=0, ADD r1 (r1=0x1) -> acc=0x0, carry=1, zflag=1; then ADC r1 -> acc=0x2, carry=0.
REQ-037 acc=0x3, SBB r2 (r2=0x3, carry=1) -> acc=0xF, carry=1; then AND r2 -> acc=0x3, carry still 1.
REQ-038 acc=0xA, XCH r4 (r4=0x6) -> rf write r4=0xA in EXEC cycle, acc=0x6.
REQ-039 op=0xC -> done and err pulse at +2 cycles, no rf_rd_en/rf_wr_en, flags unchanged; instr_valid held high during busy -> only one acceptance.
REQ-040 rst asserted during EXEC of XCH -> rf_wr_en 0 after assertion, no done, acc=0, zflag=1; new LDR accepted after release.
